kbd_scan_display: RTL
=====================

KBD_SCAN_DISPLAY -- requirements
Module: kbd_scan_display

Interface
REQ-001 Parameter NUM_BYTES, default 2: depth of the scan-code history shown on the display (1..8).
REQ-002 Parameter TIMEOUT_CYCLES, default 50000: CLOCK cycles without a PS/2 clock falling edge before a partial frame is discarded.
REQ-003 CLOCK  input  1  system clock; the block's only clock.
REQ-004 RESET  input  1  asynchronous, active-high reset.
REQ-005 SCL  input  1  PS/2 clock line, asynchronous to CLOCK.
REQ-006 SDA  input  1  PS/2 data line, asynchronous to CLOCK.
REQ-007 Key  output  8  last accepted make/break scan code.
REQ-008 KEY_VALID  output  1  one-cycle pulse when Key updates.
REQ-009 BREAK  output  1  Key is a release code (was preceded by F0).
REQ-010 EXTENDED  output  1  Key was preceded by E0.
REQ-011 FRAME_ERR  output  1  one-cycle pulse on parity, stop-bit or timeout error.
REQ-012 LED_SEG  output  14*NUM_BYTES  active-low seven-segment patterns, 7 bits per hex digit, bit 0 = segment a; digit 0 = low nibble of the newest byte.

Function
REQ-013 SCL and SDA shall each pass through a 2-flop synchronizer; a PS/2 falling edge is synced SCL going 1->0 between consecutive cycles.
REQ-014 The receiver FSM states shall be IDLE, DATA, PARITY and STOP, and all transitions shall occur only on a detected falling edge, except the timeout.
REQ-015 IDLE -> DATA on a falling edge with SDA=0 (start bit); with SDA=1, the FSM stays in IDLE and no error is flagged.
REQ-016 DATA samples 8 bits LSB first, then moves to PARITY.
REQ-017 PARITY checks odd parity over data+parity bit, then moves to STOP.
REQ-018 STOP returns to IDLE, and the frame is accepted only if parity is good and SDA=1; otherwise FRAME_ERR pulses and the byte is dropped.
REQ-019 A falling edge on the stop bit in cycle N shall produce KEY_VALID or FRAME_ERR in cycle N+1.
REQ-020 On a timeout (TIMEOUT_CYCLES consecutive cycles without a falling edge outside IDLE), the FSM returns to IDLE and FRAME_ERR pulses.
REQ-021 The timeout counter resets on every falling edge and is held at 0 in IDLE.
REQ-022 Accepted byte 0xF0 sets break_pending; accepted byte 0xE0 sets ext_pending; neither pulses KEY_VALID or changes the display.
REQ-023 Any other accepted byte: Key<=byte, BREAK<=break_pending, EXTENDED<=ext_pending, KEY_VALID pulses, and both pending flags clear in the same cycle.
REQ-024 Only make codes (BREAK=0) shift into the history register; newest at slot 0, oldest dropped, and release codes leave the display unchanged.
REQ-025 A FRAME_ERR shall clear break_pending and ext_pending.
REQ-026 Each nibble shall decode combinationally to hex glyphs 0-F, and LED_SEG shall follow the history with no added latency.

Reset
REQ-027 RESET shall asynchronously force: FSM=IDLE, bit counter, shift register and timeout counter =0, pending flags =0.
REQ-028 RESET shall asynchronously force: Key=0x00, KEY_VALID=0, BREAK=0, EXTENDED=0, FRAME_ERR=0, history=0.
REQ-029 During and after reset, every LED_SEG digit shall display "0" (7'b1000000).
REQ-030 RESET asserted mid-frame shall discard the frame, and the first frame after release starts from IDLE.

Structure
REQ-031 A shared package shall hold: the FSM state enum, constants SC_BREAK=8'hF0 and SC_EXT=8'hE0, and the 16-entry seven-segment glyph table.
REQ-032 A sub-module hex_to_seg (4-bit in, 7-bit active-low out) shall be instantiated 2*NUM_BYTES times via generate.

Verification
REQ-033 Frame 0x1C with good parity -> KEY_VALID one cycle after the stop edge, Key=0x1C, BREAK=0, digits 1:0 show "1C".
REQ-034 Frames F0,1C -> one KEY_VALID only, Key=0x1C, BREAK=1, display unchanged.
REQ-035 Frames E0,75 -> Key=0x75, EXTENDED=1, digits show "75" and previous byte moves up one slot (NUM_BYTES=2).
REQ-036 Frame with wrong parity or stop=0 -> FRAME_ERR pulse, no KEY_VALID, Key unchanged.
REQ-037 Frame stalled after 4 data bits for TIMEOUT_CYCLES -> FRAME_ERR pulse, and the next full frame 0x32 is accepted correctly.
REQ-038 RESET asserted mid-frame -> all outputs at reset values and display "00", and the next frame 0x1C is accepted.

Source files
------------

// File: rtl/kbd_scan_display_pkg.sv
// Shared types and constants for the PS/2 scan-code receiver and hex display.
package kbd_scan_display_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DATA   = 2'd1,
    ST_PARITY = 2'd2,
    ST_STOP   = 2'd3
  } rx_state_e;

  localparam logic [7:0] SC_BREAK = 8'hF0;
  localparam logic [7:0] SC_EXT   = 8'hE0;

  // Active-low seven-segment glyphs, bit 0 = segment a, indexed by nibble value.
  localparam logic [15:0][6:0] SEG_TABLE = {
    7'h0E, 7'h06, 7'h21, 7'h46,   // F E d C
    7'h03, 7'h08, 7'h10, 7'h00,   // b A 9 8
    7'h78, 7'h02, 7'h12, 7'h19,   // 7 6 5 4
    7'h30, 7'h24, 7'h79, 7'h40    // 3 2 1 0
  };

endpackage

// File: rtl/kbd_scan_display_hex_to_seg.sv
// One hex digit: 4-bit nibble to active-low seven-segment pattern.
module hex_to_seg
  import kbd_scan_display_pkg::*;
(
  input  logic [3:0] nibble,
  output logic [6:0] seg
);

  assign seg = SEG_TABLE[nibble];

endmodule

// File: rtl/kbd_scan_display.sv
// PS/2 keyboard receiver with make/break/extended decoding and a hex history display.
module kbd_scan_display
  import kbd_scan_display_pkg::*;
#(
  parameter int NUM_BYTES      = 2,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                      CLOCK,
  input  logic                      RESET,
  input  logic                      SCL,
  input  logic                      SDA,
  output logic [7:0]                Key,
  output logic                      KEY_VALID,
  output logic                      BREAK,
  output logic                      EXTENDED,
  output logic                      FRAME_ERR,
  output logic [14*NUM_BYTES-1:0]   LED_SEG
);

  localparam int              TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  rx_state_e state_q, state_d;

  logic [1:0]      scl_sync_q, scl_sync_d;
  logic [1:0]      sda_sync_q, sda_sync_d;
  logic            scl_prev_q, scl_prev_d;
  logic [2:0]      bit_cnt_q, bit_cnt_d;
  logic [7:0]      shift_q, shift_d;
  logic            par_ok_q, par_ok_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d;
  logic            brk_pend_q, brk_pend_d;
  logic            ext_pend_q, ext_pend_d;
  logic [7:0]      key_q, key_d;
  logic            key_valid_q, key_valid_d;
  logic            break_q, break_d;
  logic            ext_q, ext_d;
  logic            frame_err_q, frame_err_d;
  logic [NUM_BYTES-1:0][7:0] hist_q, hist_d;

  logic fall;
  logic sda_bit;
  logic timeout;

  assign fall    = scl_prev_q & ~scl_sync_q[1];
  assign sda_bit = sda_sync_q[1];
  assign timeout = (state_q != ST_IDLE) && !fall && (to_cnt_q == TO_LAST);

  // Synchronizer inputs: shift the raw lines in, keep last synced SCL for edge detection.
  always_comb begin
    scl_sync_d = {scl_sync_q[0], SCL};
    sda_sync_d = {sda_sync_q[0], SDA};
    scl_prev_d = scl_sync_q[1];
  end

  // Receiver state register.
  // NOTE: sequential blocks use non-blocking (<=) so every flop samples pre-edge values.
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next-state logic: moves only on a PS/2 falling edge, or back to IDLE on timeout.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (fall && !sda_bit)            state_d = ST_DATA;
      ST_DATA:   if (fall && bit_cnt_q == 3'd7)   state_d = ST_PARITY;
      ST_PARITY: if (fall)                        state_d = ST_STOP;
      ST_STOP:   if (fall)                        state_d = ST_IDLE;
      default:                                    state_d = ST_IDLE;
    endcase
    if (timeout) state_d = ST_IDLE;
  end

  // Output/datapath logic: bit capture, parity, frame acceptance and scan-code decode.
  always_comb begin
    // NOTE: every comb output gets a default first so no path can infer a latch.
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    par_ok_d    = par_ok_q;
    brk_pend_d  = brk_pend_q;
    ext_pend_d  = ext_pend_q;
    key_d       = key_q;
    break_d     = break_q;
    ext_d       = ext_q;
    hist_d      = hist_q;
    key_valid_d = 1'b0;
    frame_err_d = 1'b0;
    to_cnt_d    = (state_q == ST_IDLE || fall || timeout) ? '0 : to_cnt_q + TO_W'(1);

    if (fall) begin
      case (state_q)
        ST_IDLE: begin
          bit_cnt_d = 3'd0;
          shift_d   = 8'h00;
        end
        ST_DATA: begin
          shift_d   = {sda_bit, shift_q[7:1]};
          bit_cnt_d = bit_cnt_q + 3'd1;
        end
        ST_PARITY: par_ok_d = (^shift_q) ^ sda_bit;
        ST_STOP: begin
          if (par_ok_q && sda_bit) begin
            if (shift_q == SC_BREAK) begin
              brk_pend_d = 1'b1;
            end else if (shift_q == SC_EXT) begin
              ext_pend_d = 1'b1;
            end else begin
              key_d       = shift_q;
              break_d     = brk_pend_q;
              ext_d       = ext_pend_q;
              key_valid_d = 1'b1;
              brk_pend_d  = 1'b0;
              ext_pend_d  = 1'b0;
              if (!brk_pend_q) begin
                hist_d[0] = shift_q;
                for (int i = 1; i < NUM_BYTES; i++) hist_d[i] = hist_q[i-1];
              end
            end
          end else begin
            frame_err_d = 1'b1;
            brk_pend_d  = 1'b0;
            ext_pend_d  = 1'b0;
          end
        end
        default: ;
      endcase
    end

    if (timeout) begin
      frame_err_d = 1'b1;
      brk_pend_d  = 1'b0;
      ext_pend_d  = 1'b0;
    end
  end

  // Datapath registers; synchronizers reset to the idle-high bus level.
  // NOTE: the history is a small register file, not RAM, so it is reset so the display reads "00".
  always_ff @(posedge CLOCK or posedge RESET) begin
    if (RESET) begin
      scl_sync_q  <= 2'b11;
      sda_sync_q  <= 2'b11;
      scl_prev_q  <= 1'b1;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'h00;
      par_ok_q    <= 1'b0;
      to_cnt_q    <= '0;
      brk_pend_q  <= 1'b0;
      ext_pend_q  <= 1'b0;
      key_q       <= 8'h00;
      key_valid_q <= 1'b0;
      break_q     <= 1'b0;
      ext_q       <= 1'b0;
      frame_err_q <= 1'b0;
      hist_q      <= '0;
    end else begin
      scl_sync_q  <= scl_sync_d;
      sda_sync_q  <= sda_sync_d;
      scl_prev_q  <= scl_prev_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      par_ok_q    <= par_ok_d;
      to_cnt_q    <= to_cnt_d;
      brk_pend_q  <= brk_pend_d;
      ext_pend_q  <= ext_pend_d;
      key_q       <= key_d;
      key_valid_q <= key_valid_d;
      break_q     <= break_d;
      ext_q       <= ext_d;
      frame_err_q <= frame_err_d;
      hist_q      <= hist_d;
    end
  end

  assign Key       = key_q;
  assign KEY_VALID = key_valid_q;
  assign BREAK     = break_q;
  assign EXTENDED  = ext_q;
  assign FRAME_ERR = frame_err_q;

  // Two digits per history byte; even digit is the low nibble.
  for (genvar g = 0; g < 2*NUM_BYTES; g++) begin : g_digit
    hex_to_seg u_hex_to_seg (
      .nibble (hist_q[g/2][(g%2)*4 +: 4]),
      .seg    (LED_SEG[g*7 +: 7])
    );
  end

endmodule
